// File: rtl/stream_mux_n_1_pkg.sv
// Shared types and helpers for the N:1 packet stream multiplexer.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  function automatic int next_rr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_mux_n_1_if.sv
// Handshake bundle between N producers, the multiplexer and one consumer.
interface stream_mux_n_1_if #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
);
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_last;
  logic [SEL_W-1:0]      sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [SEL_W-1:0]      out_chan;

  // slave = the multiplexer itself, master = the surrounding producers/consumer
  modport slave (
    input  in_valid, in_data, in_last, sel, out_ready,
    output in_ready, out_valid, out_data, out_last, out_chan
  );
  modport master (
    output in_valid, in_data, in_last, sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_chan
  );
endinterface

// File: rtl/stream_mux_n_1_slice.sv
// Narrow combinational N:1 mux cell; wide buses are built by replicating it.
module mux_n_1_slice #(
  parameter  int N_IN    = 4,
  parameter  int SLICE_W = 2,
  localparam int SEL_W   = $clog2(N_IN)
) (
  input  logic [N_IN*SLICE_W-1:0] i_data,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [SLICE_W-1:0]      o_data
);

  always_comb begin
    o_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (i_sel == SEL_W'(i)) o_data = i_data[i*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/stream_mux_n_1.sv
// N:1 packet stream mux with per-packet grant lock and one registered output stage.
//   state     | meaning
//   ST_IDLE   | unlocked, candidate from sel (MODE_SEL) or round-robin scan (MODE_RR)
//   ST_LOCKED | r_grant owns the output until its last beat is accepted
module stream_mux_n_1
  import stream_mux_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int WIDTH   = 4,
  parameter int SLICE_W = 2,
  parameter int MODE    = MODE_SEL
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_n_1_if.slave io_bus
);

  localparam int SEL_W   = $clog2(N_IN);
  localparam int N_SLICE = WIDTH / SLICE_W;

  state_t              r_state;
  logic [SEL_W-1:0]    r_grant;
  logic [SEL_W-1:0]    r_rr_ptr;
  logic                r_out_valid;
  logic                r_out_last;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_chan;

  logic [SEL_W-1:0]    w_cand;
  logic                w_cand_ok;
  logic                w_load;
  logic                w_accept;
  logic                w_acc_last;
  logic [N_IN-1:0]     w_in_ready;
  logic [WIDTH-1:0]    w_mux_data;

  assign w_load = !r_out_valid || io_bus.out_ready;

  always_comb begin
    w_cand    = r_grant;
    w_cand_ok = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_cand_ok = 1'b1;
    end else if (MODE == MODE_SEL) begin
      w_cand = io_bus.sel;
      for (int i = 0; i < N_IN; i++) begin
        if (io_bus.sel == SEL_W'(i) && io_bus.in_valid[i]) w_cand_ok = 1'b1;
      end
    end else begin
      // scan offsets from the far end so the smallest offset from r_rr_ptr wins
      for (int k = N_IN - 1; k >= 0; k--) begin
        for (int i = 0; i < N_IN; i++) begin
          if (i == (int'(r_rr_ptr) + k) % N_IN && io_bus.in_valid[i]) begin
            w_cand    = SEL_W'(i);
            w_cand_ok = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_in_ready = '0;
    w_acc_last = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      w_in_ready[i] = rst_n && w_cand_ok && w_load && (w_cand == SEL_W'(i));
      if (w_cand == SEL_W'(i)) w_acc_last = io_bus.in_last[i];
    end
  end

  assign w_accept = |(w_in_ready & io_bus.in_valid);

  for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
    logic [N_IN*SLICE_W-1:0] w_slice_in;
    for (genvar i = 0; i < N_IN; i++) begin : g_ch
      assign w_slice_in[i*SLICE_W +: SLICE_W] = io_bus.in_data[i*WIDTH + s*SLICE_W +: SLICE_W];
    end
    mux_n_1_slice #(.N_IN(N_IN), .SLICE_W(SLICE_W)) u_slice (
      .i_data (w_slice_in),
      .i_sel  (w_cand),
      .o_data (w_mux_data[s*SLICE_W +: SLICE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_data <= w_mux_data;
          r_out_last <= w_acc_last;
          r_out_chan <= w_cand;
        end
      end
      if (w_accept) begin
        if (w_acc_last) begin
          r_state  <= ST_IDLE;
          r_rr_ptr <= SEL_W'(next_rr(int'(w_cand), N_IN));
        end else begin
          r_state <= ST_LOCKED;
          r_grant <= w_cand;
        end
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_last  = r_out_last;
  assign io_bus.out_chan  = r_out_chan;

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Scoreboard bench: directed stimulus pushes {chan,last,data} expectations, monitors pop on each output beat.
module tb_stream_mux_n_1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  logic [6:0] q0[$];
  logic [6:0] q1[$];
  logic [6:0] q2[$];

  always #5 clk = ~clk;

  stream_mux_n_1_if #(.N_IN(4), .WIDTH(4), .SEL_W(2)) b0 ();
  stream_mux_n_1_if #(.N_IN(4), .WIDTH(4), .SEL_W(2)) b1 ();
  stream_mux_n_1_if #(.N_IN(3), .WIDTH(4), .SEL_W(2)) b2 ();

  stream_mux_n_1 #(.N_IN(4), .WIDTH(4), .SLICE_W(2), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .io_bus(b0));
  stream_mux_n_1 #(.N_IN(4), .WIDTH(4), .SLICE_W(2), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .io_bus(b1));
  stream_mux_n_1 #(.N_IN(3), .WIDTH(4), .SLICE_W(2), .MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .io_bus(b2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon_check(input string nm, input logic [6:0] act, input logic have, input logic [6:0] exp);
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s unexpected beat actual=%0h required=none t=%0t", nm, act, $time);
    end else if (act !== exp) begin
      failures++;
      $display("FAIL %s beat actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n && b0.out_valid && b0.out_ready) begin
    if (q0.size() > 0) mon_check("sb0", {b0.out_chan, b0.out_last, b0.out_data}, 1'b1, q0.pop_front());
    else               mon_check("sb0", {b0.out_chan, b0.out_last, b0.out_data}, 1'b0, 7'h0);
  end
  always @(negedge clk) if (rst_n && b1.out_valid && b1.out_ready) begin
    if (q1.size() > 0) mon_check("sb1", {b1.out_chan, b1.out_last, b1.out_data}, 1'b1, q1.pop_front());
    else               mon_check("sb1", {b1.out_chan, b1.out_last, b1.out_data}, 1'b0, 7'h0);
  end
  always @(negedge clk) if (rst_n && b2.out_valid && b2.out_ready) begin
    if (q2.size() > 0) mon_check("sb2", {b2.out_chan, b2.out_last, b2.out_data}, 1'b1, q2.pop_front());
    else               mon_check("sb2", {b2.out_chan, b2.out_last, b2.out_data}, 1'b0, 7'h0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b0.in_valid = '0; b0.in_data = '0; b0.in_last = '0; b0.sel = '0; b0.out_ready = 1'b1;
    b1.in_valid = '0; b1.in_data = '0; b1.in_last = '0; b1.sel = '0; b1.out_ready = 1'b1;
    b2.in_valid = '0; b2.in_data = '0; b2.in_last = '0; b2.sel = '0; b2.out_ready = 1'b1;

    // reset: valids held high to show in_ready is gated
    b0.in_valid = 4'hF; b1.in_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid0", b0.out_valid, 0);
    chk("rst_in_ready0", b0.in_ready, 0);
    chk("rst_in_ready1", b1.in_ready, 0);
    cyc();
    rst_n = 1'b1; b0.in_valid = '0; b1.in_valid = '0;

    // 1: basic select
    b0.in_data = {4'hD, 4'hC, 4'hB, 4'hA}; b0.in_last = 4'hF; b0.in_valid = 4'hF;
    q0.push_back({2'd0, 1'b1, 4'hA}); q0.push_back({2'd1, 1'b1, 4'hB});
    q0.push_back({2'd2, 1'b1, 4'hC}); q0.push_back({2'd3, 1'b1, 4'hD});
    for (int k = 0; k < 4; k++) begin
      b0.sel = 2'(k);
      @(negedge clk);
      chk("t1_ready", b0.in_ready, 32'(1 << k));
      if (k > 0) chk("t1_latency", {b0.out_valid, b0.out_chan}, {1'b1, 2'(k - 1)});
      cyc();
    end
    b0.in_valid = '0;
    @(negedge clk);
    chk("t1_last_beat", {b0.out_valid, b0.out_chan, b0.out_data}, {1'b1, 2'd3, 4'hD});
    cyc();

    // 2: packet lock
    q0.push_back({2'd1, 1'b0, 4'h5}); q0.push_back({2'd1, 1'b0, 4'h6});
    q0.push_back({2'd1, 1'b1, 4'h7}); q0.push_back({2'd2, 1'b1, 4'h9});
    b0.sel = 2'd1; b0.in_valid = 4'b0110; b0.in_last = 4'b0100; b0.in_data = 16'h0950;
    @(negedge clk); chk("t2_ready_b1", b0.in_ready, 4'b0010); cyc();
    b0.sel = 2'd2; b0.in_data = 16'h0960;
    @(negedge clk); chk("t2_ready_b2", b0.in_ready, 4'b0010); cyc();
    b0.in_data = 16'h0970; b0.in_last = 4'b0110;
    @(negedge clk); chk("t2_ready_b3", b0.in_ready, 4'b0010); cyc();
    b0.in_valid = 4'b0100;
    @(negedge clk); chk("t2_ready_ch2", b0.in_ready, 4'b0100); cyc();
    b0.in_valid = '0;
    @(negedge clk); cyc();

    // 4: backpressure
    q0.push_back({2'd0, 1'b1, 4'h3}); q0.push_back({2'd0, 1'b1, 4'h4});
    b0.sel = 2'd0; b0.in_valid = 4'b0001; b0.in_last = 4'b0001; b0.in_data = 16'h0003;
    @(negedge clk); chk("t4_ready_first", b0.in_ready, 4'b0001); cyc();
    b0.out_ready = 1'b0; b0.in_data = 16'h0004;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold", {b0.out_valid, b0.out_data}, {1'b1, 4'h3});
      chk("t4_ready_zero", b0.in_ready, 4'b0000);
      cyc();
    end
    b0.out_ready = 1'b1;
    @(negedge clk); chk("t4_ready_resume", b0.in_ready, 4'b0001); cyc();
    b0.in_valid = '0;
    @(negedge clk); chk("t4_second", {b0.out_valid, b0.out_data}, {1'b1, 4'h4}); cyc();
    @(negedge clk); chk("t4_drained", b0.out_valid, 0); cyc();

    // 5: invalid select on a 3-channel mux, then a legal one
    b2.sel = 2'd3; b2.in_valid = 3'b111; b2.in_last = 3'b111; b2.in_data = 12'h751;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_ready", b2.in_ready, 3'b000);
      chk("t5_out_valid", b2.out_valid, 0);
      cyc();
    end
    q2.push_back({2'd2, 1'b1, 4'h7});
    b2.sel = 2'd2;
    @(negedge clk); chk("t5_ready_sel2", b2.in_ready, 3'b100); cyc();
    b2.in_valid = '0;
    @(negedge clk); chk("t5_out_sel2", {b2.out_valid, b2.out_data}, {1'b1, 4'h7}); cyc();

    // 3: round robin
    b1.in_data = {4'hB, 4'hA, 4'h9, 4'h8}; b1.in_last = 4'hF; b1.in_valid = 4'hF;
    q1.push_back({2'd0, 1'b1, 4'h8}); q1.push_back({2'd1, 1'b1, 4'h9});
    q1.push_back({2'd2, 1'b1, 4'hA}); q1.push_back({2'd3, 1'b1, 4'hB});
    q1.push_back({2'd0, 1'b1, 4'h8}); q1.push_back({2'd1, 1'b1, 4'h9});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t3_rr_ready", b1.in_ready, 32'(1 << (k % 4)));
      cyc();
    end
    b1.in_valid = '0;
    @(negedge clk); cyc();

    // 6: reset mid-packet on channel 2; beat 2 is dropped by the reset
    q1.push_back({2'd2, 1'b0, 4'h1});
    b1.in_valid = 4'b0100; b1.in_last = 4'b0000; b1.in_data = 16'h0100;
    @(negedge clk); chk("t6_ready_b1", b1.in_ready, 4'b0100); cyc();
    b1.in_data = 16'h0200;
    @(negedge clk); chk("t6_ready_b2", b1.in_ready, 4'b0100); cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", b1.out_valid, 0);
    chk("t6_rst_ready", b1.in_ready, 4'b0000);
    @(negedge clk); chk("t6_rst_ready_hold", b1.in_ready, 4'b0000); cyc();
    rst_n = 1'b1;
    q1.push_back({2'd0, 1'b1, 4'hE});
    b1.in_valid = 4'b0101; b1.in_last = 4'b0001; b1.in_data = 16'h030E;
    @(negedge clk); chk("t6_ready_ch0", b1.in_ready, 4'b0001); cyc();
    b1.in_valid = '0;
    @(negedge clk); chk("t6_out_e", {b1.out_valid, b1.out_chan, b1.out_data}, {1'b1, 2'd0, 4'hE}); cyc();
    cyc();

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_n_1.md
Name: stream_mux_n_1

Overview:
- Parametrised N-input, WIDTH-bit packet stream multiplexer with valid/ready handshakes on every channel and one registered output stage.
- Data path is built from narrow SLICE_W-bit N:1 slices, so wide buses reuse one small mux cell.
- Channel choice comes from an external select (MODE 0) or a round-robin arbiter (MODE 1).
- The grant is locked for a whole packet, up to and including the beat with last set.
- Sits between N producers and a single downstream consumer.

Parameters:
- N_IN, 4, number of input channels (≥2).
- WIDTH, 4, data width per channel; must be a multiple of SLICE_W.
- SLICE_W, 2, width of each narrow mux slice.
- MODE, 0, 0 = external select, 1 = round-robin.
- SEL_W, $clog2(N_IN), select and channel-id width (derived, localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  N_IN  per-channel valid.
- in_ready  out  N_IN  per-channel ready.
- in_data  in  N_IN*WIDTH  flattened data; channel i occupies [i*WIDTH +: WIDTH].
- in_last  in  N_IN  per-channel end-of-packet.
- sel  in  SEL_W  channel select; used only when MODE=0.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  WIDTH  output data.
- out_last  out  1  output end-of-packet.
- out_chan  out  SEL_W  source channel of the output beat.

Behaviour:
- **Reset:** asserting rst_n=0 immediately clears out_valid, out_last, out_data, out_chan, the lock flag, the grant register and the round-robin pointer. in_ready is all-zero while rst_n=0.
- **Output register:**
  - load = !out_valid || out_ready.
  - On load with an accepted input beat, out_* takes the beat next cycle and out_valid=1.
  - On load with no beat accepted, out_valid=0.
  - Latency is 1 cycle. Throughput is 1 beat/cycle with out_ready held high.
- **States:** IDLE (unlocked) and LOCKED(g).
- **IDLE candidate selection:**
  - MODE 0: candidate = sel if sel < N_IN and in_valid[sel]=1; otherwise there is no candidate.
  - MODE 1: candidate = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod N_IN.
- **IDLE, per cycle:**
  - in_ready[candidate] = load; all other in_ready bits are 0.
  - A beat is accepted when in_valid & in_ready are both set on the candidate.
  - Accepted with last=0: go to LOCKED(candidate).
  - Accepted with last=1: single-beat packet, stay in IDLE.
- **LOCKED(g):**
  - Only g is eligible: in_ready[g] = load.
  - sel changes and other channels' valid are ignored.
  - Leave to IDLE on the accepted beat with in_last[g]=1.
- **Round-robin pointer:** on each accepted last beat from channel g, rr_ptr ← (g+1) mod N_IN. The pointer never moves mid-packet. Reset value is 0.
- **Data path:** out_data is driven from WIDTH/SLICE_W instances of the slice sub-module, all sharing the grant index. The bit order of in_data is preserved exactly; no arithmetic is performed.
- **Backpressure:** while out_valid=1 and out_ready=0, every in_ready is 0 and out_* holds stable.
- **X handling:** data of non-selected channels must not affect out_data.
- **Reset mid-packet:** the packet is dropped, the lock is released, and the next packet restarts from IDLE with rr_ptr=0.

Decomposition:
- Package stream_mux_pkg holds:
  - mode constants MODE_SEL=0 and MODE_RR=1;
  - the state enum {ST_IDLE, ST_LOCKED};
  - a function next_rr(ptr, n) computing (ptr+1) mod n.
- Sub-module mux_n_1_slice (params N_IN, SLICE_W) is a purely combinational N:1 mux of SLICE_W bits with a SEL_W-bit index. It is generated WIDTH/SLICE_W times.

Test Plan:
1. **Basic select.** MODE0, N=4, W=4. Channel data a,b,c,d with valid=1111, last=1; sel stepped 0..3, out_ready=1. Required: out_data = a,b,c,d on successive cycles, each 1 cycle after acceptance; out_chan = 0..3; out_last=1.
2. **Packet lock.** MODE0. Ch1 sends 3-beat packet 5,6,7 (last on 7); sel switches to 2 after beat 1, with ch2 valid holding 9. Required: out_data = 5,6,7 then 9; in_ready[2]=0 until the beat with value 7 has been accepted.
3. **Round robin.** MODE1. All four channels present single-beat packets continuously (data = channel id + 8). Required: out_data = 8,9,a,b,8,…; after the channel 3 last beat rr_ptr wraps to 0.
4. **Backpressure.** out_ready=0 for 3 cycles while out_valid=1 with data 3. Required: out_data stays 3, all in_ready=0, and no beat is lost or duplicated after out_ready returns to 1.
5. **Invalid select.** MODE0, N=3 (SEL_W=2), sel=3. Required: in_ready=000 and out_valid stays 0.
6. **Reset mid-packet.** rst_n pulses low between beats 2 and 3 of a 4-beat packet. Required: out_valid=0 immediately and the lock is released. After release, a fresh single-beat packet on channel 0 (MODE1) with data e appears on out_data one cycle after acceptance.
